// File: rtl/clock_pkg.sv
// Shared encodings, timer sizing and helpers for the alarm-clock mode controller.
package clock_pkg;

  localparam int unsigned TIMER_W     = 16;
  localparam int unsigned SNOOZE_SECS = 300;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_STOPWATCH = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    RING_IDLE   = 2'd0,
    RING_RING   = 2'd1,
    RING_SNOOZE = 2'd2
  } ring_e;

  typedef struct packed {
    logic step;
    logic up;
    logic dn;
    logic sel;
  } btn_t;

  function automatic logic is_set_mode(input mode_e m);
    return (m == MODE_SET_TIME) || (m == MODE_SET_ALARM);
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CLOCK:     return MODE_SET_TIME;
      MODE_SET_TIME:  return MODE_SET_ALARM;
      MODE_SET_ALARM: return MODE_STOPWATCH;
      default:        return MODE_CLOCK;
    endcase
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Loadable seconds down-counter: decrements on tick, saturates at zero, flags zero.
module sec_timer
  import clock_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority over a coincident tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mode_controller.sv
// Alarm-clock UI controller: mode/edit FSM, idle fallback and alarm ring FSM.
// Define MODE_CTRL_SNOOZE_EN to add the SNOOZE state to the ring FSM.
module mode_controller
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECS = 60,
  parameter int unsigned IDLE_SECS = 30
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       mode_p,
  input  logic       up_p,
  input  logic       dn_p,
  input  logic       sel_p,
  input  logic       tick_1hz,
  input  logic       alarm_match,
  output logic [1:0] mode,
  output logic       sw_en,
  output logic       field,
  output logic       inc_p,
  output logic       dec_p,
  output logic       armed,
  output logic       ringing
);

  btn_t  w_btn, w_eff;
  mode_e r_mode, w_mode_nxt;
  ring_e r_ring, w_ring_nxt;

  logic r_match_d, w_match_rise, w_any_btn, w_consume;
  logic r_field, r_armed, r_inc, r_dec, r_sw_en, r_ringing;
  logic w_field_nxt, w_armed_nxt, w_inc_nxt, w_dec_nxt, w_sw_en_nxt, w_ringing_nxt;

  logic               w_idle_load, w_idle_tick, w_idle_zero;
  logic [TIMER_W-1:0] w_idle_val;
  logic               w_rt_load, w_rt_tick, w_rt_zero;
  logic [TIMER_W-1:0] w_rt_val;

  assign w_btn        = {mode_p, up_p, dn_p, sel_p};
  assign w_any_btn    = |w_btn;
  assign w_match_rise = alarm_match & ~r_match_d;
  // Any button seen while the alarm is active only silences it.
  assign w_consume    = (r_ring != RING_IDLE) & w_any_btn;
  assign w_eff        = w_consume ? '0 : w_btn;

  // ---------------- mode FSM ----------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) r_mode <= MODE_CLOCK;
    else       r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (is_set_mode(r_mode) && w_idle_zero) begin
      w_mode_nxt = MODE_CLOCK;
    end else if (w_eff.step) begin
      w_mode_nxt = next_mode(r_mode);
    end
  end

  always_comb begin
    w_field_nxt = r_field;
    w_armed_nxt = r_armed;
    w_inc_nxt   = 1'b0;
    w_dec_nxt   = 1'b0;
    w_sw_en_nxt = (w_mode_nxt == MODE_STOPWATCH);
    if (w_mode_nxt != r_mode) begin
      w_field_nxt = 1'b0;
    end else begin
      case (r_mode)
        MODE_CLOCK: begin
          if (w_eff.sel) w_armed_nxt = ~r_armed;
        end
        MODE_SET_TIME, MODE_SET_ALARM: begin
          if (w_eff.sel) w_field_nxt = ~r_field;
          w_inc_nxt = w_eff.up & ~w_eff.dn;
          w_dec_nxt = w_eff.dn & ~w_eff.up;
        end
        default: ;
      endcase
    end
  end

  // Idle fallback: reload on entry or activity in set modes, held cleared elsewhere.
  assign w_idle_load = ~is_set_mode(w_mode_nxt) | (w_mode_nxt != r_mode) | w_any_btn;
  assign w_idle_val  = is_set_mode(w_mode_nxt) ? TIMER_W'(IDLE_SECS) : '0;
  assign w_idle_tick = is_set_mode(r_mode) & tick_1hz;

  sec_timer #(.W(TIMER_W)) u_idle_timer (
    .i_clk      (clk),
    .i_rst      (RESET),
    .i_load     (w_idle_load),
    .i_load_val (w_idle_val),
    .i_tick     (w_idle_tick),
    .o_zero     (w_idle_zero)
  );

  // ---------------- ring FSM ----------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) r_ring <= RING_IDLE;
    else       r_ring <= w_ring_nxt;
  end

  always_comb begin
    w_ring_nxt = r_ring;
    case (r_ring)
      RING_IDLE: begin
        if (w_match_rise && r_armed) w_ring_nxt = RING_RING;
      end
      RING_RING: begin
        if (w_rt_zero) w_ring_nxt = RING_IDLE;
`ifdef MODE_CTRL_SNOOZE_EN
        else if (w_btn.sel) w_ring_nxt = RING_SNOOZE;
`endif
        else if (w_any_btn) w_ring_nxt = RING_IDLE;
      end
`ifdef MODE_CTRL_SNOOZE_EN
      RING_SNOOZE: begin
        if (w_btn.step || w_btn.up || w_btn.dn) w_ring_nxt = RING_IDLE;
        else if (w_rt_zero)                     w_ring_nxt = RING_RING;
      end
`endif
      default: w_ring_nxt = RING_IDLE;
    endcase
  end

  always_comb begin
    w_ringing_nxt = (w_ring_nxt == RING_RING);
  end

  assign w_rt_load = (w_ring_nxt != r_ring) && (w_ring_nxt != RING_IDLE);
  assign w_rt_tick = (r_ring != RING_IDLE) & tick_1hz;
`ifdef MODE_CTRL_SNOOZE_EN
  assign w_rt_val  = (w_ring_nxt == RING_SNOOZE) ? TIMER_W'(SNOOZE_SECS) : TIMER_W'(RING_SECS);
`else
  assign w_rt_val  = TIMER_W'(RING_SECS);
`endif

  sec_timer #(.W(TIMER_W)) u_ring_timer (
    .i_clk      (clk),
    .i_rst      (RESET),
    .i_load     (w_rt_load),
    .i_load_val (w_rt_val),
    .i_tick     (w_rt_tick),
    .o_zero     (w_rt_zero)
  );

  // ---------------- output registers ----------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_match_d <= 1'b0;
      r_field   <= 1'b0;
      r_armed   <= 1'b0;
      r_inc     <= 1'b0;
      r_dec     <= 1'b0;
      r_sw_en   <= 1'b0;
      r_ringing <= 1'b0;
    end else begin
      r_match_d <= alarm_match;
      r_field   <= w_field_nxt;
      r_armed   <= w_armed_nxt;
      r_inc     <= w_inc_nxt;
      r_dec     <= w_dec_nxt;
      r_sw_en   <= w_sw_en_nxt;
      r_ringing <= w_ringing_nxt;
    end
  end

  assign mode    = r_mode;
  assign sw_en   = r_sw_en;
  assign field   = r_field;
  assign inc_p   = r_inc;
  assign dec_p   = r_dec;
  assign armed   = r_armed;
  assign ringing = r_ringing;

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller; covers MODE_CTRL_SNOOZE_EN when defined.
module tb_mode_controller;

  typedef struct packed {
    logic [1:0] mode;
    logic       sw_en;
    logic       field;
    logic       inc;
    logic       dec;
    logic       armed;
    logic       ringing;
  } obs_t;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_MODE = 4'b1000;
  localparam logic [3:0] B_UP   = 4'b0100;
  localparam logic [3:0] B_DN   = 4'b0010;
  localparam logic [3:0] B_SEL  = 4'b0001;

  logic       clk = 1'b0;
  logic       RESET;
  logic       mode_p, up_p, dn_p, sel_p, tick_1hz, alarm_match;
  logic [1:0] mode;
  logic       sw_en, field, inc_p, dec_p, armed, ringing;

  obs_t  e;
  obs_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  mode_controller dut (
    .clk         (clk),
    .RESET       (RESET),
    .mode_p      (mode_p),
    .up_p        (up_p),
    .dn_p        (dn_p),
    .sel_p       (sel_p),
    .tick_1hz    (tick_1hz),
    .alarm_match (alarm_match),
    .mode        (mode),
    .sw_en       (sw_en),
    .field       (field),
    .inc_p       (inc_p),
    .dec_p       (dec_p),
    .armed       (armed),
    .ringing     (ringing)
  );

  always #5 clk = ~clk;

  task automatic check_pop();
    obs_t  ex, ob;
    string tg;
    ex = exp_q.pop_front();
    tg = tag_q.pop_front();
    ob = {mode, sw_en, field, inc_p, dec_p, armed, ringing};
    n_cmp++;
    assert (ob === ex) else begin
      n_err++;
      $error("FAIL %s: observed mode=%0d sw=%b fld=%b inc=%b dec=%b arm=%b ring=%b expected mode=%0d sw=%b fld=%b inc=%b dec=%b arm=%b ring=%b",
             tg, ob.mode, ob.sw_en, ob.field, ob.inc, ob.dec, ob.armed, ob.ringing,
             ex.mode, ex.sw_en, ex.field, ex.inc, ex.dec, ex.armed, ex.ringing);
    end
  endtask

  task automatic sample_now(input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    check_pop();
  endtask

  // One clock: drive buttons/tick, queue the expected post-edge outputs, compare after the edge.
  task automatic cyc(input string tag, input logic [3:0] b, input logic tk);
    {mode_p, up_p, dn_p, sel_p} = b;
    tick_1hz = tk;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    {mode_p, up_p, dn_p, sel_p} = B_NONE;
    tick_1hz = 1'b0;
    check_pop();
  endtask

  initial begin
    RESET = 1'b1;
    {mode_p, up_p, dn_p, sel_p} = B_NONE;
    tick_1hz = 1'b0;
    alarm_match = 1'b0;
    e = '0;
    repeat (2) @(posedge clk);
    #1;
    sample_now("reset_state");
    RESET = 1'b0;

    // Mode cycling
    e.mode = 2'd1;                cyc("mode_to_set_time", B_MODE, 1'b0);
    e.mode = 2'd2;                cyc("mode_to_set_alarm", B_MODE, 1'b0);
    e.mode = 2'd3; e.sw_en = 1'b1; cyc("mode_to_stopwatch", B_MODE, 1'b0);
    cyc("sw_up_no_inc", B_UP, 1'b0);
    cyc("sw_sel_ignored", B_SEL, 1'b0);
    e.mode = 2'd0; e.sw_en = 1'b0; cyc("mode_to_clock", B_MODE, 1'b0);

    // CLOCK mode: sel arms, up does nothing
    e.armed = 1'b1; cyc("clock_sel_arms", B_SEL, 1'b0);
    cyc("clock_up_no_inc", B_UP, 1'b0);

    // SET_TIME edits
    e.mode = 2'd1; cyc("enter_set_time", B_MODE, 1'b0);
    e.inc = 1'b1;  cyc("up_gives_inc", B_UP, 1'b0);
    e.inc = 1'b0;  cyc("inc_single_cycle", B_NONE, 1'b0);
    e.dec = 1'b1;  cyc("dn_gives_dec", B_DN, 1'b0);
    e.dec = 1'b0;  cyc("dec_single_cycle", B_NONE, 1'b0);
    e.field = 1'b1; cyc("sel_toggles_field", B_SEL, 1'b0);
    cyc("up_dn_together", B_UP | B_DN, 1'b0);
    cyc("up_dn_after", B_NONE, 1'b0);

    // SET_ALARM idle fallback with restart at tick 29
    e.mode = 2'd2; e.field = 1'b0; cyc("enter_set_alarm", B_MODE, 1'b0);
    for (int k = 1; k <= 28; k++) cyc("idle_pre_tick", B_NONE, 1'b1);
    e.field = 1'b1; cyc("idle_restart_tick29", B_SEL, 1'b1);
    for (int k = 1; k <= 30; k++) cyc("idle_after_restart", B_NONE, 1'b1);
    e.mode = 2'd0; e.field = 1'b0; cyc("idle_timeout_clock", B_NONE, 1'b0);

    // Ring for 60 ticks
    alarm_match = 1'b1;
    e.ringing = 1'b1; cyc("ring_start", B_NONE, 1'b0);
    for (int k = 1; k <= 60; k++) cyc("ring_hold", B_NONE, 1'b1);
    e.ringing = 1'b0; cyc("ring_timeout", B_NONE, 1'b0);
    alarm_match = 1'b0; cyc("match_fall", B_NONE, 1'b0);

    // Button while ringing is consumed
    e.mode = 2'd1; cyc("enter_set_time2", B_MODE, 1'b0);
    alarm_match = 1'b1;
    e.ringing = 1'b1; cyc("ring_in_set_time", B_NONE, 1'b0);
    e.ringing = 1'b0; cyc("up_consumed", B_UP, 1'b0);
    cyc("no_late_inc", B_NONE, 1'b0);
    alarm_match = 1'b0; cyc("match_fall2", B_NONE, 1'b0);
    alarm_match = 1'b1;
    e.ringing = 1'b1; cyc("ring_again", B_NONE, 1'b0);
    e.ringing = 1'b0; cyc("mode_consumed", B_MODE, 1'b0);
    alarm_match = 1'b0; cyc("match_fall3", B_NONE, 1'b0);

    // Simultaneous alarm edge and mode_p
    alarm_match = 1'b1;
    e.mode = 2'd2; e.ringing = 1'b1; cyc("edge_and_mode", B_MODE, 1'b0);

    // Asynchronous reset while ringing with an edit pending
    up_p = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    e = '0;
    sample_now("async_reset");
    @(posedge clk);
    #1;
    RESET = 1'b0;
    up_p = 1'b0;
    alarm_match = 1'b0;
    cyc("post_reset_quiet", B_NONE, 1'b0);
    cyc("post_reset_quiet2", B_NONE, 1'b0);

`ifdef MODE_CTRL_SNOOZE_EN
    e.armed = 1'b1; cyc("snz_arm", B_SEL, 1'b0);
    alarm_match = 1'b1;
    e.ringing = 1'b1; cyc("snz_ring_start", B_NONE, 1'b0);
    e.ringing = 1'b0; cyc("snz_enter", B_SEL, 1'b0);
    for (int k = 1; k <= 300; k++) cyc("snz_quiet", B_NONE, 1'b1);
    e.ringing = 1'b1; cyc("snz_resume", B_NONE, 1'b0);
    e.ringing = 1'b0; cyc("snz_mode_stop", B_MODE, 1'b0);
    cyc("snz_stays_idle", B_NONE, 1'b1);
    alarm_match = 1'b0; cyc("snz_match_fall", B_NONE, 1'b0);
`else
    e.armed = 1'b1; cyc("arm_again", B_SEL, 1'b0);
    alarm_match = 1'b1;
    e.ringing = 1'b1; cyc("ring_clock", B_NONE, 1'b0);
    e.ringing = 1'b0; cyc("sel_stops_keeps_armed", B_SEL, 1'b0);
    cyc("no_snooze_resume", B_NONE, 1'b1);
    alarm_match = 1'b0; cyc("match_fall4", B_NONE, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
